led_request_arbiter: RTL and testbench
======================================

Name: led_request_arbiter

Overview:
Shares the 8-LED bank between several status sources (SPGD loop state, error flags, debug). Each source requests the LEDs with a pattern and an optional blink attribute. The block grants one owner by fixed priority, enforces a minimum display time, and produces the registered 8-bit value that feeds the LED driver's val input.

Parameters:
LED_WIDTH, 8, LED bank width.
NUM_REQ, 4, number of requesters (1..8); index 0 has highest priority.
TICK_DIV, 125000, clk_i cycles per time tick (1 ms at 125 MHz); must be >= 2.
HOLD_TICKS, 100, minimum ticks an owner keeps the LEDs; must be >= 1.
BLINK_TICKS, 250, ticks per blink half-period; must be >= 1.

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  synchronous, active-high reset.
req_i  in  NUM_REQ  per-requester request level.
pattern_i  in  NUM_REQ*LED_WIDTH  requester k pattern at bits [k*LED_WIDTH +: LED_WIDTH].
blink_i  in  NUM_REQ  per-requester blink enable.
led_val_o  out  LED_WIDTH  registered LED value for the LED driver.
grant_o  out  NUM_REQ  one-hot current owner; all-zero when idle.
busy_o  out  1  high while any owner is granted.

Behaviour:
- Reset: one clock with rst_i high forces state IDLE, and led_val_o, grant_o, busy_o, tick, hold, blink and heartbeat counters to 0. Reset applies mid-operation with no draining.
- Tick: free-running counter 0..TICK_DIV-1. A one-cycle tick pulse fires on the wrap cycle. Not cleared by arbitration.
- FSM states: IDLE, OWNED.
- IDLE, any req_i high at cycle N:
  - The lowest-index requester wins. grant_o and busy_o are set at N+1.
  - Its pattern_i and blink_i are latched, hold_cnt loads HOLD_TICKS, blink counter clears, and blink phase is set to ON.
- OWNED:
  - While the owner's req_i is high, its pattern/blink are re-latched every cycle. While it is low, the last latched values persist (pulse stretch).
  - hold_cnt decrements on each tick and saturates at 0.
  - Re-arbitration happens only when hold_cnt==0 AND (owner req low OR a higher-priority req high).
  - On re-arbitration, if any req is high, the highest-priority requester is granted in the same transition (no IDLE gap), with a fresh load and blink reset. Otherwise go to IDLE with grant_o=0 and busy_o=0.
  - Lower-priority requests never preempt.
  - Owner re-asserting req after dropping it, before expiry, continues ownership without reloading hold_cnt.
- Blink: if the latched blink bit is 1, the phase toggles every BLINK_TICKS ticks. Otherwise the phase is held ON.
- Output: led_val_o at cycle N+1 reflects FSM state/latches registered at N. Total latency from req_i to led_val_o is 2 cycles.
  - OWNED: led_val_o = phase ON ? latched pattern : 0.
  - IDLE: led_val_o = 0, or the heartbeat output when that feature is enabled.
- Widths: counters sized with $clog2 of their maximum. pattern_i is sliced by index with no width truncation.

Optional Feature:
LED_ARB_HEARTBEAT_EN.
- Defined: in IDLE, led_val_o[0] toggles every 2*BLINK_TICKS ticks and other bits are 0. The heartbeat counter clears and bit 0 starts OFF on each entry to IDLE. busy_o stays 0.
- Undefined: IDLE output is constant 0 and no heartbeat logic exists.

Test Plan:
All scenarios use NUM_REQ=4, TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2.
- Reset: rst_i high 3 cycles with req_i=4'b1111 -> led_val_o=0x00, grant_o=0, busy_o=0 throughout. After release, grant_o=4'b0001 one cycle later.
- Single owner: req_i[2]=1, pattern 0xA5, blink 0 at cycle N -> grant_o=4'b0100 at N+1, led_val_o=0xA5 from N+2, held while req stays high.
- Pulse stretch: req_i[1] high for 1 cycle, pattern 0x3C -> led_val_o=0x3C held 9..12 cycles until hold expiry, then 0x00 and busy_o=0.
- Preemption: req3 granted (pattern 0x0F); req0 (0xF0) raised the next cycle -> grant stays 4'b1000 until hold_cnt=0, then grant_o=4'b0001 and led_val_o=0xF0 one cycle later. No idle cycle between owners.
- Blink: req0 pattern 0xFF, blink 1 -> led_val_o alternates 0xFF/0x00 every 8 cycles, starting 0xFF.
- Heartbeat (LED_ARB_HEARTBEAT_EN defined), no requests -> led_val_o toggles 0x00/0x01 every 16 cycles. Undefined -> constant 0x00.

Source files
------------

// File: rtl/led_request_arbiter.sv
// Fixed-priority LED bank arbiter with minimum hold time and blink.
// Optional idle heartbeat on bit 0: define LED_ARB_HEARTBEAT_EN.
module led_request_arbiter #(
  parameter int LED_WIDTH   = 8,
  parameter int NUM_REQ     = 4,
  parameter int TICK_DIV    = 125000,
  parameter int HOLD_TICKS  = 100,
  parameter int BLINK_TICKS = 250
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*LED_WIDTH-1:0] pattern_i,
  input  logic [NUM_REQ-1:0]           blink_i,
  output logic [LED_WIDTH-1:0]         led_val_o,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         busy_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [HW-1:0]        hold_cnt;
  logic [BW-1:0]        blink_cnt;
  logic                 phase;
  logic [LED_WIDTH-1:0] pat_q;
  logic                 blink_q;
  logic [LED_WIDTH-1:0] idle_val;

  logic                 tick;
  logic [NUM_REQ-1:0]   pick;
  logic                 own_req;
  logic                 hi_req;
  logic                 hold_done;
  logic                 rearb;
  logic                 grab;

  function automatic logic [LED_WIDTH-1:0] pat_sel(
    input logic [NUM_REQ-1:0]           oh,
    input logic [NUM_REQ*LED_WIDTH-1:0] p
  );
    pat_sel = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (oh[k]) pat_sel |= p[k*LED_WIDTH +: LED_WIDTH];
  endfunction

  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign pick    = req_i & (~req_i + NUM_REQ'(1));
  assign own_req = |(req_i & grant_o);
  assign hi_req  = |(req_i & (grant_o - NUM_REQ'(1)));

  // Hold expires on the tick that takes the count to zero.
  assign hold_done = (hold_cnt == '0) ||
                     (hold_cnt == HW'(1) && tick);
  assign rearb = (state == OWNED) && hold_done &&
                 (!own_req || hi_req);
  assign grab  = (|req_i) && (state == IDLE || rearb);

`ifdef LED_ARB_HEARTBEAT_EN
  localparam int HBW = $clog2(2 * BLINK_TICKS + 1);
  logic [HBW-1:0] hb_cnt;
  logic           hb_bit;
  assign idle_val = LED_WIDTH'(hb_bit);
`else
  assign idle_val = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      pat_q     <= '0;
      blink_q   <= 1'b0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      led_val_o <= '0;
`ifdef LED_ARB_HEARTBEAT_EN
      hb_cnt    <= '0;
      hb_bit    <= 1'b0;
`endif
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      led_val_o <= (state == OWNED) ?
                   (phase ? pat_q : '0) : idle_val;
      if (grab) begin
        state     <= OWNED;
        grant_o   <= pick;
        busy_o    <= 1'b1;
        pat_q     <= pat_sel(pick, pattern_i);
        blink_q   <= |(blink_i & pick);
        hold_cnt  <= HW'(HOLD_TICKS);
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (rearb) begin
        state   <= IDLE;
        grant_o <= '0;
        busy_o  <= 1'b0;
`ifdef LED_ARB_HEARTBEAT_EN
        hb_cnt  <= '0;
        hb_bit  <= 1'b0;
`endif
      end else if (state == OWNED) begin
        if (own_req) begin
          pat_q   <= pat_sel(grant_o, pattern_i);
          blink_q <= |(blink_i & grant_o);
        end
        if (tick && hold_cnt != '0)
          hold_cnt <= hold_cnt - HW'(1);
        if (!blink_q) begin
          phase     <= 1'b1;
          blink_cnt <= '0;
        end else if (tick) begin
          if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      end else begin
`ifdef LED_ARB_HEARTBEAT_EN
        if (tick) begin
          if (hb_cnt == HBW'(2 * BLINK_TICKS - 1)) begin
            hb_cnt <= '0;
            hb_bit <= ~hb_bit;
          end else begin
            hb_cnt <= hb_cnt + HBW'(1);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_led_request_arbiter.sv
// Randomized and directed bench for led_request_arbiter against an
// integer-based behavioural model of the arbitration rules.
module tb_led_request_arbiter;

  localparam int LW = 8;
  localparam int NR = 4;
  localparam int TD = 4;
  localparam int HT = 3;
  localparam int BT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*LW-1:0] pattern = '0;
  logic [NR-1:0]    blink = '0;
  logic [LW-1:0]    led_val_o;
  logic [NR-1:0]    grant_o;
  logic             busy_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_request_arbiter #(
    .LED_WIDTH(LW), .NUM_REQ(NR), .TICK_DIV(TD),
    .HOLD_TICKS(HT), .BLINK_TICKS(BT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .pattern_i(pattern), .blink_i(blink),
    .led_val_o(led_val_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  // Reference model: owner index (-1 idle), ticks elapsed since grant,
  // blink ticks elapsed, idle ticks elapsed.
  int            m_owner = -1;
  int            m_tcnt = 0;
  int            m_held = 0;
  int            m_bt = 0;
  int            m_ht = 0;
  logic [LW-1:0] m_pat = '0;
  logic          m_blink = 1'b0;
  logic [LW-1:0] exp_led = '0;
  logic [NR-1:0] exp_grant = '0;
  logic          exp_busy = 1'b0;

  function automatic int lowest(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic m_take(input int k);
    m_owner = k;
    m_held  = 0;
    m_bt    = 0;
    m_pat   = pattern[k*LW +: LW];
    m_blink = blink[k];
  endtask

  always @(posedge clk) begin : model
    int tk;
    int hi;
    logic [LW-1:0] nled;
    if (rst) begin
      m_owner = -1; m_tcnt = 0; m_held = 0; m_bt = 0; m_ht = 0;
      m_pat = '0; m_blink = 1'b0; exp_led = '0;
    end else begin
      tk = (m_tcnt == TD - 1) ? 1 : 0;
      m_tcnt = (m_tcnt + 1) % TD;
      if (m_owner >= 0)
        nled = (((m_bt / BT) % 2) == 0) ? m_pat : '0;
      else
`ifdef LED_ARB_HEARTBEAT_EN
        nled = LW'((m_ht / (2 * BT)) % 2);
`else
        nled = '0;
`endif
      hi = lowest(req);
      if (m_owner < 0) begin
        if (hi >= 0) m_take(hi);
        else m_ht += tk;
      end else if ((m_held + tk >= HT) &&
                   (!req[m_owner] || (hi >= 0 && hi < m_owner))) begin
        if (hi >= 0) m_take(hi);
        else begin m_owner = -1; m_ht = 0; end
      end else begin
        if (m_blink) m_bt += tk; else m_bt = 0;
        m_held += tk;
        if (req[m_owner]) begin
          m_pat   = pattern[m_owner*LW +: LW];
          m_blink = blink[m_owner];
        end
      end
      exp_led = nled;
    end
    exp_grant = (m_owner >= 0) ? NR'(1) << m_owner : '0;
    exp_busy  = (m_owner >= 0);
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; blink = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; pattern = 32'h1122_3344;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({led_val_o, grant_o, busy_o} !== 13'd0) begin
        miscompares++;
        $display("FAIL reset c%0d: led=%h grant=%b busy=%b want 0",
                 c, led_val_o, grant_o, busy_o);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (grant_o !== 4'b0001 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: grant=%b busy=%b want 0001 1",
               grant_o, busy_o);
    end
    req = '0;
  endtask

  task automatic test_single_owner();
    pulse_reset();
    pattern[2*LW +: LW] = 8'hA5; blink = '0; req = 4'b0100;
    @(negedge clk);
    vectors++;
    if (grant_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_grant: grant=%b want 0100", grant_o);
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      vectors++;
      if (led_val_o !== 8'hA5 || grant_o !== 4'b0100 ||
          {led_val_o, grant_o, busy_o} !== {exp_led, exp_grant, exp_busy}) begin
        miscompares++;
        $display("FAIL single c%0d: led=%h grant=%b want A5 0100 (model %h %b)",
                 c, led_val_o, grant_o, exp_led, exp_grant);
      end
    end
    req = '0;
  endtask

  task automatic test_pulse_stretch();
    int on_cnt = 0;
    pulse_reset();
    pattern[LW +: LW] = 8'h3C; req = 4'b0010;
    @(negedge clk);
    req = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (led_val_o === 8'h3C) on_cnt++;
      vectors++;
      if ({led_val_o, grant_o, busy_o} !== {exp_led, exp_grant, exp_busy}) begin
        miscompares++;
        $display("FAIL stretch c%0d: led=%h grant=%b busy=%b want %h %b %b",
                 c, led_val_o, grant_o, busy_o, exp_led, exp_grant, exp_busy);
      end
    end
    vectors++;
    if (on_cnt < 9 || on_cnt > 12 || busy_o !== 1'b0 || led_val_o !== 8'h00) begin
      miscompares++;
      $display("FAIL stretch_len: on=%0d busy=%b led=%h want 9..12 0 00",
               on_cnt, busy_o, led_val_o);
    end
  endtask

  task automatic test_preemption();
    int sw = -1;
    pulse_reset();
    pattern[3*LW +: LW] = 8'h0F; pattern[0 +: LW] = 8'hF0;
    req = 4'b1000;
    @(negedge clk);
    req = 4'b1001;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (sw < 0 && grant_o === 4'b0001) sw = c;
      vectors++;
      if ((sw < 0 && grant_o !== 4'b1000) || busy_o !== 1'b1 ||
          (sw >= 0 && c == sw + 1 && led_val_o !== 8'hF0) ||
          {led_val_o, grant_o, busy_o} !== {exp_led, exp_grant, exp_busy}) begin
        miscompares++;
        $display("FAIL preempt c%0d: led=%h grant=%b busy=%b model %h %b",
                 c, led_val_o, grant_o, busy_o, exp_led, exp_grant);
      end
    end
    vectors++;
    if (sw < 7) begin
      miscompares++;
      $display("FAIL preempt_switch: switched at %0d want >=7", sw);
    end
    req = '0;
  endtask

  task automatic test_blink();
    logic [LW-1:0] prev = 8'h00;
    int run = 0;
    int segs = 0;
    pulse_reset();
    pattern[0 +: LW] = 8'hFF; blink = 4'b0001; req = 4'b0001;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (led_val_o !== prev) begin
        vectors++;
        if ((segs == 0 && led_val_o !== 8'hFF) ||
            (segs >= 2 && run != 8)) begin
          miscompares++;
          $display("FAIL blink_seg%0d: led=%h run=%0d want FF first, 8 cycles",
                   segs, led_val_o, run);
        end
        segs++; run = 0; prev = led_val_o;
      end
      run++;
      vectors++;
      if ({led_val_o, grant_o, busy_o} !== {exp_led, exp_grant, exp_busy}) begin
        miscompares++;
        $display("FAIL blink c%0d: led=%h want %h", c, led_val_o, exp_led);
      end
    end
    vectors++;
    if (segs < 5) begin
      miscompares++;
      $display("FAIL blink_count: %0d segments want >=5", segs);
    end
    req = '0; blink = '0;
  endtask

  task automatic test_idle();
    int toggles = 0;
    logic [LW-1:0] prev = 8'h00;
    pulse_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (led_val_o !== prev) toggles++;
      prev = led_val_o;
      vectors++;
      if (led_val_o > 8'h01 || busy_o !== 1'b0 ||
          {led_val_o, grant_o, busy_o} !== {exp_led, exp_grant, exp_busy}) begin
        miscompares++;
        $display("FAIL idle c%0d: led=%h busy=%b want %h 0",
                 c, led_val_o, busy_o, exp_led);
      end
    end
    vectors++;
`ifdef LED_ARB_HEARTBEAT_EN
    if (toggles < 2) begin
`else
    if (toggles != 0) begin
`endif
      miscompares++;
      $display("FAIL idle_toggles: %0d toggles", toggles);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0)
        req = NR'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) pattern = $urandom;
      if ($urandom_range(0, 15) == 0) blink = NR'($urandom_range(0, 15));
      @(negedge clk);
      vectors++;
      if ({led_val_o, grant_o, busy_o} !== {exp_led, exp_grant, exp_busy}) begin
        miscompares++;
        $display("FAIL random c%0d: led=%h grant=%b busy=%b want %h %b %b",
                 c, led_val_o, grant_o, busy_o, exp_led, exp_grant, exp_busy);
      end
    end
    req = 4'b0001; pattern = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({led_val_o, grant_o, busy_o} !== 13'd0) begin
      miscompares++;
      $display("FAIL midop_reset: led=%h grant=%b busy=%b want 0",
               led_val_o, grant_o, busy_o);
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_pulse_stretch();
    test_preemption();
    test_blink();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
